// File: rtl/ir_key_decoder_pkg.sv
// Shared definitions for the NEC key decoder: FSM state encoding and the frame field layout
// (the field offsets are also used by the IR receiver that builds the frames).
package ir_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } ir_state_e;

   localparam int FRAME_W    = 32;
   localparam int FIELD_W    = 8;
   localparam int ADDR_LSB   = 24;
   localparam int ADDR_N_LSB = 16;
   localparam int CMD_LSB    = 8;
   localparam int CMD_N_LSB  = 0;

   // A frame is trustworthy only when both bytes arrive together with their inverted copies.
   function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
      return (f[ADDR_N_LSB +: FIELD_W] == ~f[ADDR_LSB +: FIELD_W]) &&
             (f[CMD_N_LSB  +: FIELD_W] == ~f[CMD_LSB  +: FIELD_W]);
   endfunction

endpackage

// File: rtl/ir_key_decoder_if.sv
// Frame/repeat input strobes and key event outputs of the NEC key decoder.
// master drives the frames (receiver side), slave is the decoder.
interface ir_key_decoder_if;
   import ir_pkg::*;

   logic                 i_frame_vld;
   logic [FRAME_W-1:0]   i_frame;
   logic                 i_rpt_vld;
   logic                 o_key_vld;
   logic                 o_key_rpt;
   logic                 o_key_rel;
   logic [FIELD_W-1:0]   o_key_code;
   logic [FIELD_W-1:0]   o_key_addr;
   logic                 o_key_held;
   logic [7:0]           o_err_cnt;

   modport master (
      output i_frame_vld, i_frame, i_rpt_vld,
      input  o_key_vld, o_key_rpt, o_key_rel, o_key_code, o_key_addr, o_key_held, o_err_cnt
   );

   modport slave (
      input  i_frame_vld, i_frame, i_rpt_vld,
      output o_key_vld, o_key_rpt, o_key_rel, o_key_code, o_key_addr, o_key_held, o_err_cnt
   );

endinterface

// File: rtl/ir_key_decoder_ms_tick.sv
// Free-running 1 ms prescaler: o_tick is high for one cycle every CLK_HZ/1000 clocks.
module ir_ms_tick #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/ir_key_decoder.sv
// Turns checked NEC frames and repeat codes into press / auto-repeat / release key events.
// Build option IR_ADDR_FILTER_EN: silently drop well-formed frames whose address differs from ADDR.
module ir_key_decoder
   import ir_pkg::*;
#(
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          RELEASE_MS = 120,
   parameter int          HOLD_DLY   = 3,
   parameter logic [7:0]  ADDR       = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   ir_key_decoder_if.slave    bus
);

   localparam logic [7:0] RELOAD = 8'(RELEASE_MS);
   localparam logic [3:0] HOLD   = 4'(HOLD_DLY);

   ir_state_e          r_state, w_state_nxt;
   logic [7:0]         r_timeout, w_timeout_nxt;
   logic [3:0]         r_rpt_cnt, w_rpt_cnt_nxt;
   logic [3:0]         w_rpt_inc;
   logic [7:0]         r_err_cnt, w_err_cnt_nxt;
   logic               r_key_vld, w_key_vld_nxt;
   logic               r_key_rpt, w_key_rpt_nxt;
   logic               r_key_rel, w_key_rel_nxt;
   logic [FIELD_W-1:0] r_code, w_code_nxt;
   logic [FIELD_W-1:0] r_addr, w_addr_nxt;
   logic               w_tick;
   logic               w_frame_ok;
   logic               w_addr_ok;
   logic               w_accept;
   logic               w_reject;

   ir_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   assign w_frame_ok = frame_ok(bus.i_frame);

`ifdef IR_ADDR_FILTER_EN
   assign w_addr_ok = (bus.i_frame[ADDR_LSB +: FIELD_W] == ADDR);
`else
   assign w_addr_ok = 1'b1;
`endif

   // A foreign-address frame is neither accepted nor an error, but it still masks a same-cycle repeat.
   assign w_accept  = bus.i_frame_vld & w_frame_ok & w_addr_ok;
   assign w_reject  = bus.i_frame_vld & ~w_frame_ok;
   assign w_rpt_inc = r_rpt_cnt + 4'd1;

   // Next-state logic; priority is accepted frame, then repeat code, then the ms tick.
   always_comb begin
      w_state_nxt   = r_state;
      w_timeout_nxt = r_timeout;
      w_rpt_cnt_nxt = r_rpt_cnt;
      w_err_cnt_nxt = r_err_cnt;
      w_code_nxt    = r_code;
      w_addr_nxt    = r_addr;
      w_key_vld_nxt = 1'b0;
      w_key_rpt_nxt = 1'b0;
      w_key_rel_nxt = 1'b0;

      if (w_reject && (r_err_cnt != 8'hFF)) begin
         w_err_cnt_nxt = r_err_cnt + 8'd1;
      end

      if (w_accept) begin
         w_state_nxt   = PRESSED;
         w_timeout_nxt = RELOAD;
         w_rpt_cnt_nxt = 4'd0;
         w_code_nxt    = bus.i_frame[CMD_LSB +: FIELD_W];
         w_addr_nxt    = bus.i_frame[ADDR_LSB +: FIELD_W];
         w_key_vld_nxt = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            PRESSED, HELD: begin
               if (bus.i_rpt_vld && !bus.i_frame_vld) begin
                  w_timeout_nxt = RELOAD;
                  if (r_state == PRESSED) begin
                     w_rpt_cnt_nxt = w_rpt_inc;
                     if (w_rpt_inc >= HOLD) begin
                        w_state_nxt = HELD;
                     end
                  end else begin
                     w_key_vld_nxt = 1'b1;
                     w_key_rpt_nxt = 1'b1;
                  end
               end else if (w_tick) begin
                  if (r_timeout <= 8'd1) begin
                     w_timeout_nxt = 8'd0;
                     w_state_nxt   = IDLE;
                     w_key_rel_nxt = 1'b1;
                  end else begin
                     w_timeout_nxt = r_timeout - 8'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset drops any key silently, without a release strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_timeout <= 8'd0;
         r_rpt_cnt <= 4'd0;
         r_err_cnt <= 8'd0;
         r_code    <= '0;
         r_addr    <= '0;
         r_key_vld <= 1'b0;
         r_key_rpt <= 1'b0;
         r_key_rel <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timeout <= w_timeout_nxt;
         r_rpt_cnt <= w_rpt_cnt_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_code    <= w_code_nxt;
         r_addr    <= w_addr_nxt;
         r_key_vld <= w_key_vld_nxt;
         r_key_rpt <= w_key_rpt_nxt;
         r_key_rel <= w_key_rel_nxt;
      end
   end

   assign bus.o_key_vld  = r_key_vld;
   assign bus.o_key_rpt  = r_key_rpt;
   assign bus.o_key_rel  = r_key_rel;
   assign bus.o_key_code = r_code;
   assign bus.o_key_addr = r_addr;
   assign bus.o_key_held = (r_state != IDLE);
   assign bus.o_err_cnt  = r_err_cnt;

endmodule
